mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port 16x512 RAM between two masters: port 0 (CPU) and port 1 (loader/DMA).
//   Grants at most one memory command per cycle. Routes returned read data back to the issuer.
//   Bounds consecutive grants to one port so the other cannot starve.
//   Sits between the CPU mem_cmd/mem_addr/w_data/r_data pins and the RAM.
// PARAMETERS
//   HOLD_MAX  4  max consecutive grants to one port while the other port is waiting (>=1)
//   PRIO0     1  1: port 0 wins a contended request from IDLE; 0: port 1 wins
// PORTS
//   clk         in   1   single clock, rising edge
//   reset       in   1   synchronous, active-high
//   req0_cmd    in   2   port 0 command: 00 NONE, 01 READ, 10 WRITE, 11 treated as NONE
//   req0_addr   in   9   port 0 word address
//   req0_wdata  in   16  port 0 write data
//   req0_ready  out  1   port 0 command issued to RAM this cycle
//   req0_rvalid out  1   req0_rdata holds port 0 read result this cycle
//   req0_rdata  out  16  read data to port 0
//   req1_cmd    in   2   port 1 command, same encoding
//   req1_addr   in   9   port 1 word address
//   req1_wdata  in   16  port 1 write data
//   req1_ready  out  1   port 1 command issued this cycle
//   req1_rvalid out  1   req1_rdata holds port 1 read result this cycle
//   req1_rdata  out  16  read data to port 1
//   mem_cmd     out  2   command to RAM, same encoding
//   mem_addr    out  9   address to RAM
//   mem_wdata   out  16  write data to RAM
//   mem_rdata   in   16  RAM read data, valid 1 cycle after a READ issue
// BEHAVIOUR
//   - State reg: IDLE, OWN0, OWN1. 3-bit hold counter cnt (saturating). Reset -> IDLE, cnt=0.
//   - A port requests when its cmd is 01 or 10.
//   - Grant g is combinational from state, cnt and the requests:
//     * one requester: it wins.
//     * both, IDLE: PRIO0 decides.
//     * both, OWNx: x wins if cnt<HOLD_MAX, else the other port wins.
//   - Granted cycle: mem_cmd/addr/wdata = granted port's inputs; its ready=1; the other ready=0.
//   - No grant: mem_cmd=00, mem_addr=0, mem_wdata=0, both ready=0.
//   - A requester holds cmd/addr/wdata stable until it sees ready=1. It may drop the request only after ready.
//   - Next state:
//     * grant to current owner: cnt+1 (saturating).
//     * grant to the other port: owner=g, cnt=1.
//     * no request: IDLE, cnt=0.
//   - cnt counts grants, whether or not the other port is waiting. The HOLD_MAX limit applies only in contended cycles.
//   - Read return:
//     * registered rd_pend/rd_port are set when a READ is granted in cycle t.
//     * reqN_rvalid=1 in cycle t+1 only for the issuing port.
//     * reqN_rdata=mem_rdata (pass-through, both ports); meaningful only when rvalid=1.
//   - Back-to-back READs: one rvalid per cycle, in issue order. A WRITE never produces rvalid.
//   - reset=1 in any cycle:
//     * comb outputs forced: mem_cmd=00, both ready=0, both rvalid=0.
//     * next cycle: IDLE, cnt=0, rd_pend=0. A read issued before reset is dropped, with no rvalid.
//   - Simultaneous read return and new grant are independent: rvalid for the old read, ready for the new command.
//   - Reset values: ready0/1=0, rvalid0/1=0, mem_cmd=00, mem_addr=0, mem_wdata=0.
// TESTING
//   1. reset high 2 cycles, no requests
//      -> mem_cmd=00, all ready/rvalid=0, state IDLE.
//   2. req0 READ 0x005 alone at t; RAM returns 16'hABCD at t+1
//      -> t: ready0=1, mem_cmd=01, mem_addr=0x005; t+1: rvalid0=1, rdata=ABCD, rvalid1=0.
//   3. req1 WRITE 0x1FF, data 16'h1234, alone
//      -> mem_cmd=10, mem_addr=0x1FF, mem_wdata=1234, ready1=1; no rvalid on either port.
//   4. both ports hold READ continuously from IDLE, HOLD_MAX=4, PRIO0=1
//      -> grant order 0,0,0,0,1,1,1,1,0...; each rvalid one cycle after its ready.
//   5. req0 READ granted at t, reset=1 at t+1
//      -> rvalid0=0 at t+1 and t+2; IDLE after reset; next request granted normally.
//   6. req0_cmd=11 with req1 idle
//      -> no grant, mem_cmd=00, ready0=0; the same with req1 READ -> port 1 granted.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of the single-port 16x512 RAM.
// Port 0 is the CPU, port 1 the loader/DMA; grants are hold-bounded.
module mem_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter bit PRIO0    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req0_cmd,
    input  logic [8:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    output logic        req0_rvalid,
    output logic [15:0] req0_rdata,
    input  logic [1:0]  req1_cmd,
    input  logic [8:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        req1_rvalid,
    output logic [15:0] req1_rdata,
    output logic [1:0]  mem_cmd,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_port_q, rd_port_d;

    logic        v0, v1;
    logic        gnt0, gnt1;
    logic        hold_ok;
    logic [1:0]  g_cmd;

    assign v0 = (req0_cmd == CMD_READ) || (req0_cmd == CMD_WRITE);
    assign v1 = (req1_cmd == CMD_READ) || (req1_cmd == CMD_WRITE);

    // The current owner may keep the RAM only while under the hold limit.
    assign hold_ok = (int'(cnt_q) < HOLD_MAX);

    // Pick at most one port per cycle; reset suppresses every grant.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (v0 && !v1) begin
            gnt0 = 1'b1;
        end else if (v1 && !v0) begin
            gnt1 = 1'b1;
        end else if (v0 && v1) begin
            unique case (state_q)
                OWN0: begin
                    gnt0 = hold_ok;
                    gnt1 = !hold_ok;
                end
                OWN1: begin
                    gnt1 = hold_ok;
                    gnt0 = !hold_ok;
                end
                default: begin
                    gnt0 = PRIO0;
                    gnt1 = !PRIO0;
                end
            endcase
        end
    end

    // Steer the granted port's command onto the RAM pins.
    always_comb begin
        mem_cmd   = CMD_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_cmd   = req0_cmd;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (gnt1) begin
            mem_cmd   = req1_cmd;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end
    end

    assign g_cmd      = mem_cmd;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Read data is shared; rvalid says whose it is.
    assign req0_rdata  = mem_rdata;
    assign req1_rdata  = mem_rdata;
    assign req0_rvalid = !reset && rd_pend_q && !rd_port_q;
    assign req1_rvalid = !reset && rd_pend_q && rd_port_q;

    // Ownership, hold count and read tracking for the next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_pend_d = 1'b0;
        rd_port_d = rd_port_q;
        if (reset) begin
            state_d   = IDLE;
            cnt_d     = 3'd0;
            rd_pend_d = 1'b0;
        end else if (!gnt0 && !gnt1) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
        end else begin
            if ((gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1)) begin
                cnt_d = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
            end else begin
                state_d = gnt0 ? OWN0 : OWN1;
                cnt_d   = 3'd1;
            end
            rd_pend_d = (g_cmd == CMD_READ);
            rd_port_d = gnt1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            rd_pend_q <= 1'b0;
            rd_port_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            rd_port_q <= rd_port_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a tiny pattern RAM.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req0_cmd;
    logic [8:0]  req0_addr;
    logic [15:0] req0_wdata;
    logic        req0_ready;
    logic        req0_rvalid;
    logic [15:0] req0_rdata;
    logic [1:0]  req1_cmd;
    logic [8:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic        req1_ready;
    logic        req1_rvalid;
    logic [15:0] req1_rdata;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.HOLD_MAX(4), .PRIO0(1'b1)) dut (
        .clk(clk),
        .reset(reset),
        .req0_cmd(req0_cmd),
        .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid),
        .req0_rdata(req0_rdata),
        .req1_cmd(req1_cmd),
        .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid),
        .req1_rdata(req1_rdata),
        .mem_cmd(mem_cmd),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-only RAM stand-in: address 5 holds ABCD, others a fixed pattern.
    function automatic logic [15:0] pat(input logic [8:0] a);
        if (a == 9'h005) return 16'hABCD;
        return {7'd0, a} ^ 16'h5A00;
    endfunction

    always @(posedge clk) begin
        if (mem_cmd == 2'b01) mem_rdata <= pat(mem_addr);
        else mem_rdata <= 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_both();
        req0_cmd = 2'b00;
        req1_cmd = 2'b00;
    endtask

    int gseq [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int pg;

    initial begin
        reset      = 1'b1;
        mem_rdata  = 16'h0000;
        req0_cmd   = 2'b00;
        req0_addr  = 9'h000;
        req0_wdata = 16'h0000;
        req1_cmd   = 2'b00;
        req1_addr  = 9'h000;
        req1_wdata = 16'h0000;

        // 1: reset, then reset with a live request still forces idle outputs
        @(negedge clk);
        check("rst_cmd", 32'(mem_cmd), 0);
        check("rst_rdy0", 32'(req0_ready), 0);
        check("rst_rdy1", 32'(req1_ready), 0);
        check("rst_rv0", 32'(req0_rvalid), 0);
        check("rst_rv1", 32'(req1_rvalid), 0);
        tick();
        req0_cmd  = 2'b01;
        req0_addr = 9'h033;
        @(negedge clk);
        check("rst_req_cmd", 32'(mem_cmd), 0);
        check("rst_req_addr", 32'(mem_addr), 0);
        check("rst_req_rdy0", 32'(req0_ready), 0);
        tick();
        reset    = 1'b0;
        req0_cmd = 2'b00;
        tick();
        check("post_rst_rv0", 32'(req0_rvalid), 0);

        // 2: port 0 read of 0x005
        req0_cmd  = 2'b01;
        req0_addr = 9'h005;
        @(negedge clk);
        check("rd_rdy0", 32'(req0_ready), 1);
        check("rd_rdy1", 32'(req1_ready), 0);
        check("rd_cmd", 32'(mem_cmd), 1);
        check("rd_addr", 32'(mem_addr), 32'h005);
        tick();
        idle_both();
        @(negedge clk);
        check("rd_rv0", 32'(req0_rvalid), 1);
        check("rd_data0", 32'(req0_rdata), 32'hABCD);
        check("rd_rv1", 32'(req1_rvalid), 0);
        check("rd_idle_cmd", 32'(mem_cmd), 0);
        check("rd_idle_rdy0", 32'(req0_ready), 0);
        tick();

        // 3: port 1 write
        req1_cmd   = 2'b10;
        req1_addr  = 9'h1FF;
        req1_wdata = 16'h1234;
        @(negedge clk);
        check("wr_cmd", 32'(mem_cmd), 2);
        check("wr_addr", 32'(mem_addr), 32'h1FF);
        check("wr_data", 32'(mem_wdata), 32'h1234);
        check("wr_rdy1", 32'(req1_ready), 1);
        check("wr_rdy0", 32'(req0_ready), 0);
        check("wr_rv0", 32'(req0_rvalid), 0);
        tick();
        idle_both();
        @(negedge clk);
        check("wr_after_rv0", 32'(req0_rvalid), 0);
        check("wr_after_rv1", 32'(req1_rvalid), 0);
        tick();

        // 4: continuous contention from IDLE
        req0_cmd  = 2'b01;
        req0_addr = 9'h010;
        req1_cmd  = 2'b01;
        req1_addr = 9'h020;
        pg = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("ct_rdy0_%0d", i), 32'(req0_ready),
                  32'(gseq[i] == 0));
            check($sformatf("ct_rdy1_%0d", i), 32'(req1_ready),
                  32'(gseq[i] == 1));
            check($sformatf("ct_rv0_%0d", i), 32'(req0_rvalid),
                  32'(pg == 0));
            check($sformatf("ct_rv1_%0d", i), 32'(req1_rvalid),
                  32'(pg == 1));
            if (pg == 0) check($sformatf("ct_d0_%0d", i),
                               32'(req0_rdata), 32'h5A10);
            if (pg == 1) check($sformatf("ct_d1_%0d", i),
                               32'(req1_rdata), 32'h5A20);
            pg = gseq[i];
            tick();
        end
        idle_both();
        @(negedge clk);
        check("ct_last_rv0", 32'(req0_rvalid), 1);
        check("ct_last_d0", 32'(req0_rdata), 32'h5A10);
        check("ct_last_rv1", 32'(req1_rvalid), 0);
        tick();

        // 5: read dropped by reset
        req0_cmd  = 2'b01;
        req0_addr = 9'h005;
        @(negedge clk);
        check("rr_rdy0", 32'(req0_ready), 1);
        tick();
        idle_both();
        reset = 1'b1;
        @(negedge clk);
        check("rr_rv0_t1", 32'(req0_rvalid), 0);
        check("rr_cmd_t1", 32'(mem_cmd), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rr_rv0_t2", 32'(req0_rvalid), 0);
        tick();
        req1_cmd  = 2'b01;
        req1_addr = 9'h1FF;
        @(negedge clk);
        check("rr_new_rdy1", 32'(req1_ready), 1);
        check("rr_new_addr", 32'(mem_addr), 32'h1FF);
        tick();
        idle_both();
        @(negedge clk);
        check("rr_new_rv1", 32'(req1_rvalid), 1);
        check("rr_new_d1", 32'(req1_rdata), 32'h5BFF);
        tick();
        req0_cmd  = 2'b10;
        req0_addr = 9'h044;
        req1_cmd  = 2'b10;
        req1_addr = 9'h055;
        @(negedge clk);
        check("rr_prio_rdy0", 32'(req0_ready), 1);
        check("rr_prio_rdy1", 32'(req1_ready), 0);
        check("rr_prio_addr", 32'(mem_addr), 32'h044);
        tick();
        idle_both();
        tick();

        // 6: command 11 is not a request
        req0_cmd = 2'b11;
        @(negedge clk);
        check("c11_cmd", 32'(mem_cmd), 0);
        check("c11_rdy0", 32'(req0_ready), 0);
        check("c11_rdy1", 32'(req1_ready), 0);
        tick();
        req1_cmd  = 2'b01;
        req1_addr = 9'h010;
        @(negedge clk);
        check("c11_rv0", 32'(req0_rvalid), 0);
        check("c11b_rdy1", 32'(req1_ready), 1);
        check("c11b_rdy0", 32'(req0_ready), 0);
        check("c11b_cmd", 32'(mem_cmd), 1);
        check("c11b_addr", 32'(mem_addr), 32'h010);
        tick();
        idle_both();
        @(negedge clk);
        check("c11b_rv1", 32'(req1_rvalid), 1);
        check("c11b_d1", 32'(req1_rdata), 32'h5A10);
        check("c11b_rv0", 32'(req0_rvalid), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
